bcd_to_binary: RTL

BCD_TO_BINARY -- requirements
Module: bcd_to_binary

---
 rtl/bcd_to_binary.sv | 113 +++++++++++
 1 files changed

// File: rtl/bcd_to_binary.sv
// Sequential packed-BCD to binary converter: one decimal digit per enabled clock,
// most significant digit first, with sticky bad-digit and overflow flags.
module bcd_to_binary #(
  parameter int unsigned DIGITS = 10,
  parameter int unsigned BIN_W  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ce_i,
  input  logic                  start_i,
  input  logic [4*DIGITS-1:0]   dat_bcd_i,
  input  logic [3:0]            width_i,
  output logic [BIN_W-1:0]      dat_binary_o,
  output logic                  done_o,
  output logic                  busy_o,
  output logic                  err_digit_o,
  output logic                  err_ovf_o
);

  localparam int unsigned ACC_W    = BIN_W + 4;
  localparam int unsigned IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [3:0]  DIGITS_W = 4'(DIGITS);

  typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

  state_e              state_q;
  logic [4*DIGITS-1:0] bcd_q;
  logic [IDX_W-1:0]    idx_q;
  logic [ACC_W-1:0]    acc_q;
  logic [BIN_W-1:0]    bin_q;
  logic                done_q;
  logic                busy_q;
  logic                err_digit_q;
  logic                err_ovf_q;

  logic [3:0]       w_eff;
  logic [3:0]       digit;
  logic [ACC_W-1:0] step;
  logic             err_digit_d;
  logic             err_ovf_d;

  always_comb begin
    w_eff = (width_i > DIGITS_W) ? DIGITS_W : width_i;
    digit = 4'd0;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (int'(idx_q) == k) digit = bcd_q[4*k +: 4];
    end
    // acc stays below 2^BIN_W until overflow is flagged, so *10+15 cannot wrap ACC_W bits
    step        = acc_q * ACC_W'(10) + ACC_W'(digit);
    err_digit_d = err_digit_q | (digit > 4'd9);
    err_ovf_d   = err_ovf_q | (|step[ACC_W-1:BIN_W]);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= StIdle;
      bcd_q       <= '0;
      idx_q       <= '0;
      acc_q       <= '0;
      bin_q       <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      err_digit_q <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else if (ce_i) begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            // Zero width runs a single step on a cleared digit so latency is still one cycle
            bcd_q       <= (w_eff == 4'd0) ? '0 : dat_bcd_i;
            idx_q       <= (w_eff == 4'd0) ? '0 : IDX_W'(w_eff - 4'd1);
            acc_q       <= '0;
            err_digit_q <= 1'b0;
            err_ovf_q   <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= StConv;
          end
        end
        StConv: begin
          acc_q       <= step;
          err_digit_q <= err_digit_d;
          err_ovf_q   <= err_ovf_d;
          if (idx_q == '0) begin
            state_q <= StDone;
            done_q  <= 1'b1;
            if (err_digit_d)    bin_q <= '0;
            else if (err_ovf_d) bin_q <= '1;
            else                bin_q <= step[BIN_W-1:0];
          end else begin
            idx_q <= idx_q - IDX_W'(1);
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dat_binary_o = bin_q;
  assign done_o       = done_q;
  assign busy_o       = busy_q;
  assign err_digit_o  = err_digit_q;
  assign err_ovf_o    = err_ovf_q;

endmodule
